// File: rtl/clock_pkg.sv
// Shared definitions for the clock front-panel blocks: digit indices,
// per-digit BCD limits, edit FSM encoding and the digit increment helper.
package clock_pkg;

    // Digit positions, most significant first (matches edit_digit encoding)
    localparam logic [2:0] DIG_HS = 3'd0;
    localparam logic [2:0] DIG_HG = 3'd1;
    localparam logic [2:0] DIG_MS = 3'd2;
    localparam logic [2:0] DIG_MG = 3'd3;
    localparam logic [2:0] DIG_SS = 3'd4;
    localparam logic [2:0] DIG_SG = 3'd5;

    // Upper limits of each BCD digit
    localparam logic [3:0] HS_MAX    = 4'd2;
    localparam logic [3:0] HG_MAX    = 4'd9;
    localparam logic [3:0] HG_MAX_20 = 4'd3;
    localparam logic [3:0] MS_MAX    = 4'd5;
    localparam logic [3:0] MG_MAX    = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Index 0 is hour_shi, index 5 is sec_ge
    typedef logic [0:5][3:0] digits_t;

    // Increment a digit, wrapping to zero once it would pass its limit
    function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] lim);
        logic [3:0] res;
        if (v >= lim) begin
            res = 4'd0;
        end else begin
            res = v + 4'd1;
        end
        return res;
    endfunction

    // Increment the selected digit of HH:MM:SS; moving hour_shi to 2
    // pulls hour_ge down to 3 so the hour never exceeds 23.
    function automatic digits_t inc_digit(input digits_t d, input logic [2:0] sel);
        digits_t res;
        res = d;
        case (sel)
            DIG_HS: begin
                res[DIG_HS] = wrap_inc(d[DIG_HS], HS_MAX);
                if ((res[DIG_HS] == HS_MAX) && (d[DIG_HG] > HG_MAX_20)) begin
                    res[DIG_HG] = HG_MAX_20;
                end else begin
                    res[DIG_HG] = d[DIG_HG];
                end
            end
            DIG_HG:  res[DIG_HG] = wrap_inc(d[DIG_HG], (d[DIG_HS] < HS_MAX) ? HG_MAX : HG_MAX_20);
            DIG_MS:  res[DIG_MS] = wrap_inc(d[DIG_MS], MS_MAX);
            DIG_MG:  res[DIG_MG] = wrap_inc(d[DIG_MG], MG_MAX);
            DIG_SS:  res[DIG_SS] = wrap_inc(d[DIG_SS], MS_MAX);
            DIG_SG:  res[DIG_SG] = wrap_inc(d[DIG_SG], MG_MAX);
            default: res = d;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stability counter and
// rising-edge detector. press is a registered single-cycle pulse per
// accepted 0->1 transition of the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 50000,
    parameter int          CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CNT);

    logic [1:0]       r_sync;
    logic             r_sync_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             w_synced;

    assign w_synced = r_sync[1];
    assign press    = r_press;

    // Synchronize, time the stable period and update the debounced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= 2'b00;
            r_sync_prev <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
            r_level     <= 1'b0;
            r_press     <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], btn_raw};
            r_sync_prev <= w_synced;
            r_press     <= 1'b0;
            if (w_synced != r_sync_prev) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_cnt != CNT_TOP) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_level != w_synced) begin
                r_level <= w_synced;
                r_press <= w_synced;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

endmodule

// File: rtl/time_set_entry.sv
// Front-panel HH:MM:SS entry: three debounced buttons edit a local copy of
// the running time, and a commit pulses set_time_finish for one cycle.
// Optional feature macro: TIME_SET_TIMEOUT_EN (idle auto-abort of EDIT,
// restoring the digits held before entry).
module time_set_entry
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 50000,
    parameter int          CNT_W        = 16,
    parameter int unsigned TIMEOUT_CNT  = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic [3:0] cur_sec_ge,
    input  logic [3:0] cur_sec_shi,
    input  logic [3:0] cur_min_ge,
    input  logic [3:0] cur_min_shi,
    input  logic [3:0] cur_hour_ge,
    input  logic [3:0] cur_hour_shi,
    output logic [3:0] set_sec_ge,
    output logic [3:0] set_sec_shi,
    output logic [3:0] set_min_ge,
    output logic [3:0] set_min_shi,
    output logic [3:0] set_hour_ge,
    output logic [3:0] set_hour_shi,
    output logic       set_time_finish,
    output logic       editing,
    output logic [2:0] edit_digit
);

    logic    w_press_mode;
    logic    w_press_next;
    logic    w_press_inc;
    digits_t w_cur;

    state_t     r_state,   w_state_nx;
    digits_t    r_dig,     w_dig_nx;
    logic [2:0] r_sel,     w_sel_nx;
    logic       r_editing, w_editing_nx;
    logic       r_finish,  w_finish_nx;
`ifdef TIME_SET_TIMEOUT_EN
    digits_t     r_saved,    w_saved_nx;
    logic [28:0] r_idle_cnt, w_idle_cnt_nx;
    logic        w_any_press;
    localparam logic [28:0] IDLE_LAST = 29'(TIMEOUT_CNT - 32'd1);
`endif

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_db_mode (
        .clk(clk), .rst(rst), .btn_raw(btn_mode), .press(w_press_mode));
    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_db_next (
        .clk(clk), .rst(rst), .btn_raw(btn_next), .press(w_press_next));
    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_db_inc (
        .clk(clk), .rst(rst), .btn_raw(btn_inc), .press(w_press_inc));

    assign w_cur = {cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge};

    assign set_hour_shi    = r_dig[DIG_HS];
    assign set_hour_ge     = r_dig[DIG_HG];
    assign set_min_shi     = r_dig[DIG_MS];
    assign set_min_ge      = r_dig[DIG_MG];
    assign set_sec_shi     = r_dig[DIG_SS];
    assign set_sec_ge      = r_dig[DIG_SG];
    assign set_time_finish = r_finish;
    assign editing         = r_editing;
    assign edit_digit      = r_sel;

    // Next-state and next-output logic; mode beats next beats inc
    always_comb begin
        w_state_nx   = r_state;
        w_dig_nx     = r_dig;
        w_sel_nx     = r_sel;
        w_editing_nx = r_editing;
        w_finish_nx  = 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
        w_saved_nx    = r_saved;
        w_idle_cnt_nx = 29'd0;
        w_any_press   = w_press_mode | w_press_next | w_press_inc;
`endif
        case (r_state)
            IDLE: begin
                if (w_press_mode) begin
                    w_state_nx   = EDIT;
                    w_dig_nx     = w_cur;
                    w_sel_nx     = DIG_HS;
                    w_editing_nx = 1'b1;
`ifdef TIME_SET_TIMEOUT_EN
                    w_saved_nx   = r_dig;
`endif
                end else begin
                    w_editing_nx = 1'b0;
                end
            end
            EDIT: begin
                if (w_press_mode) begin
                    w_state_nx   = COMMIT;
                    w_finish_nx  = 1'b1;
                    w_editing_nx = 1'b0;
                end else if (w_press_next) begin
                    w_sel_nx = (r_sel >= DIG_SG) ? DIG_HS : (r_sel + 3'd1);
                end else if (w_press_inc) begin
                    w_dig_nx = inc_digit(r_dig, r_sel);
                end else begin
`ifdef TIME_SET_TIMEOUT_EN
                    // Idle in EDIT: abandon the edit once the budget runs out
                    if (r_idle_cnt >= IDLE_LAST) begin
                        w_state_nx   = IDLE;
                        w_editing_nx = 1'b0;
                        w_dig_nx     = r_saved;
                    end else begin
                        w_idle_cnt_nx = r_idle_cnt + 29'd1;
                    end
`else
                    w_state_nx = EDIT;
`endif
                end
`ifdef TIME_SET_TIMEOUT_EN
                if (w_any_press) begin
                    w_idle_cnt_nx = 29'd0;
                end else begin
                    w_idle_cnt_nx = w_idle_cnt_nx;
                end
`endif
            end
            COMMIT: begin
                w_state_nx   = IDLE;
                w_editing_nx = 1'b0;
            end
            default: begin
                w_state_nx   = IDLE;
                w_editing_nx = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dig      <= 24'd0;
            r_sel      <= 3'd0;
            r_editing  <= 1'b0;
            r_finish   <= 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
            r_saved    <= 24'd0;
            r_idle_cnt <= 29'd0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_dig      <= w_dig_nx;
            r_sel      <= w_sel_nx;
            r_editing  <= w_editing_nx;
            r_finish   <= w_finish_nx;
`ifdef TIME_SET_TIMEOUT_EN
            r_saved    <= w_saved_nx;
            r_idle_cnt <= w_idle_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_time_set_entry.sv
// Scoreboard bench for time_set_entry (DEBOUNCE_CNT=4, TIMEOUT_CNT=50).
// Timeout checks are active when TIME_SET_TIMEOUT_EN is defined.
module tb_time_set_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_next, btn_inc;
    logic [3:0] cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi;
    logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
    logic       set_time_finish, editing;
    logic [2:0] edit_digit;

    int n_total  = 0;
    int n_bad    = 0;
    int n_strobe = 0;

    typedef struct {
        string       tag;
        logic [23:0] set;
        logic [2:0]  dig;
        logic        edt;
    } exp_t;

    exp_t        sb_q[$];
    logic [23:0] cq[$];

    // Reference model state: digits hs,hg,ms,mg,ss,sg
    int m_d[6];
    int m_sv[6];
    int c_d[6];
    int m_sel;
    bit m_edit;

    time_set_entry #(.DEBOUNCE_CNT(4), .CNT_W(16), .TIMEOUT_CNT(50)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .cur_sec_ge(cur_sec_ge), .cur_sec_shi(cur_sec_shi),
        .cur_min_ge(cur_min_ge), .cur_min_shi(cur_min_shi),
        .cur_hour_ge(cur_hour_ge), .cur_hour_shi(cur_hour_shi),
        .set_sec_ge(set_sec_ge), .set_sec_shi(set_sec_shi),
        .set_min_ge(set_min_ge), .set_min_shi(set_min_shi),
        .set_hour_ge(set_hour_ge), .set_hour_shi(set_hour_shi),
        .set_time_finish(set_time_finish), .editing(editing), .edit_digit(edit_digit)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] dut_set();
        return {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge};
    endfunction

    function automatic logic [23:0] model_set();
        return {4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3]), 4'(m_d[4]), 4'(m_d[5])};
    endfunction

    task automatic set_cur(input int hh, input int mm, input int ss);
        c_d[0] = hh / 10; c_d[1] = hh % 10;
        c_d[2] = mm / 10; c_d[3] = mm % 10;
        c_d[4] = ss / 10; c_d[5] = ss % 10;
        cur_hour_shi = 4'(c_d[0]); cur_hour_ge = 4'(c_d[1]);
        cur_min_shi  = 4'(c_d[2]); cur_min_ge  = 4'(c_d[3]);
        cur_sec_shi  = 4'(c_d[4]); cur_sec_ge  = 4'(c_d[5]);
    endtask

    // Expected effect of one accepted press, highest priority button wins
    task automatic model_apply(input bit m, input bit n, input bit i);
        if (!m_edit) begin
            if (m) begin
                m_sv = m_d; m_d = c_d; m_sel = 0; m_edit = 1'b1;
            end
        end else if (m) begin
            m_edit = 1'b0;
            cq.push_back(model_set());
        end else if (n) begin
            m_sel = (m_sel == 5) ? 0 : m_sel + 1;
        end else if (i) begin
            case (m_sel)
                0: begin
                    m_d[0] = (m_d[0] + 1) % 3;
                    if (m_d[0] == 2 && m_d[1] > 3) m_d[1] = 3;
                end
                1:       m_d[1] = (m_d[1] + 1) % ((m_d[0] == 2) ? 4 : 10);
                2, 4:    m_d[m_sel] = (m_d[m_sel] + 1) % 6;
                default: m_d[m_sel] = (m_d[m_sel] + 1) % 10;
            endcase
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag; e.set = model_set(); e.dig = 3'(m_sel); e.edt = m_edit;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, "_set"},  32'(dut_set()),  32'(e.set));
            check_val({e.tag, "_dig"},  32'(edit_digit), 32'(e.dig));
            check_val({e.tag, "_edit"}, 32'(editing),    32'(e.edt));
        end
    endtask

    task automatic press(input bit m, input bit n, input bit i, input string tag);
        @(negedge clk);
        btn_mode = m; btn_next = n; btn_inc = i;
        model_apply(m, n, i);
        push_exp(tag);
        repeat (10) @(negedge clk);
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        repeat (10) @(negedge clk);
        check_pop();
    endtask

    // Strobe monitor: every commit strobe must match a queued commit value
    always @(negedge clk) begin
        if (set_time_finish === 1'b1) begin
            n_strobe++;
            check_val("strobe_editing", 32'(editing), 32'd0);
            if (cq.size() == 0) begin
                check_val("strobe_unexpected", 32'd1, 32'd0);
            end else begin
                check_val("strobe_set", 32'(dut_set()), 32'(cq.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        rst = 1'b1; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        set_cur(0, 0, 0);
        m_d = '{0, 0, 0, 0, 0, 0}; m_sv = m_d; m_sel = 0; m_edit = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_set",    32'(dut_set()),        32'd0);
        check_val("rst_finish", 32'(set_time_finish),  32'd0);
        check_val("rst_edit",   32'(editing),          32'd0);
        check_val("rst_dig",    32'(edit_digit),       32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: entry load
        set_cur(12, 34, 56);
        s0 = n_strobe;
        press(1'b1, 1'b0, 1'b0, "t1_entry");
        check_val("t1_set_literal", 32'(dut_set()), 32'h123456);
        check_val("t1_no_strobe", 32'(n_strobe - s0), 32'd0);
        press(1'b1, 1'b0, 1'b0, "t1_commit");

        // 2: hour wrap and clamp
        set_cur(19, 59, 59);
        press(1'b1, 1'b0, 1'b0, "t2_entry");
        press(1'b0, 1'b0, 1'b1, "t2_inc1");
        check_val("t2_clamp_literal", 32'(dut_set()), 32'h235959);
        press(1'b0, 1'b0, 1'b1, "t2_inc2");
        check_val("t2_wrap_literal", 32'(dut_set()), 32'h035959);

        // 3: digit walk with wrap, then sec_shi wrap
        for (int k = 0; k < 6; k++) press(1'b0, 1'b1, 1'b0, "t3_next");
        check_val("t3_dig_home", 32'(edit_digit), 32'd0);
        for (int k = 0; k < 4; k++) press(1'b0, 1'b1, 1'b0, "t3_to_ss");
        press(1'b0, 1'b0, 1'b1, "t3_ss_inc_first");
        check_val("t3_ss_wrap", 32'(set_sec_shi), 32'd0);
        for (int k = 0; k < 5; k++) press(1'b0, 1'b0, 1'b1, "t3_ss_inc");

        // 4: bouncing inc button yields one increment
        @(negedge clk);
        model_apply(1'b0, 1'b0, 1'b1);
        push_exp("t4_bounce");
        for (int k = 0; k < 10; k++) begin
            btn_inc = ~btn_inc;
            repeat (2) @(negedge clk);
        end
        btn_inc = 1'b1;
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        repeat (10) @(negedge clk);
        check_pop();

        // 5: mode and inc together commits without incrementing
        s0 = n_strobe;
        press(1'b1, 1'b0, 1'b1, "t5_mode_inc");
        check_val("t5_strobe_cnt", 32'(n_strobe - s0), 32'd1);

        // 6: reset mid-edit
        set_cur(12, 34, 56);
        press(1'b1, 1'b0, 1'b0, "t6_entry");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("t6_rst_set",    32'(dut_set()),       32'd0);
        check_val("t6_rst_edit",   32'(editing),         32'd0);
        check_val("t6_rst_dig",    32'(edit_digit),      32'd0);
        check_val("t6_rst_finish", 32'(set_time_finish), 32'd0);
        m_d = '{0, 0, 0, 0, 0, 0}; m_sel = 0; m_edit = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        press(1'b1, 1'b0, 1'b0, "t6_reentry");
        press(1'b1, 1'b0, 1'b0, "t6_commit");
        set_cur(8, 0, 0);
        press(1'b1, 1'b0, 1'b0, "t6_entry2");
        press(1'b0, 1'b0, 1'b1, "t6_inc");
        s0 = n_strobe;
`ifdef TIME_SET_TIMEOUT_EN
        for (int k = 0; k < 150 && editing === 1'b1; k++) @(negedge clk);
        m_d = m_sv; m_edit = 1'b0;
        check_val("t6_to_edit",     32'(editing),         32'd0);
        check_val("t6_to_set",      32'(dut_set()),       32'(model_set()));
        check_val("t6_to_literal",  32'(dut_set()),       32'h123456);
        check_val("t6_to_no_strobe", 32'(n_strobe - s0),  32'd0);
`else
        repeat (80) @(negedge clk);
        check_val("t6_persist_edit", 32'(editing),   32'd1);
        check_val("t6_persist_set",  32'(dut_set()), 32'h180000);
        press(1'b1, 1'b0, 1'b0, "t6_final_commit");
        check_val("t6_final_strobe", 32'(n_strobe - s0), 32'd1);
`endif

        repeat (5) @(negedge clk);
        check_val("commit_q_drained", 32'(cq.size()),   32'd0);
        check_val("sb_q_drained",     32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
